// File: rtl/io_handshake_unit_pkg.sv
// Shared types for the board I/O handshake unit: FSM state encodings and datapath default.
package io_handshake_unit_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IN_IDLE    = 2'd0,
    IN_WAIT    = 2'd1,
    IN_READY   = 2'd2,
    IN_RELEASE = 2'd3
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_WAIT = 2'd1,
    OUT_DONE = 2'd2
  } out_state_t;

endpackage

// File: rtl/io_handshake_unit_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, debounced level and
// a one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      cnt         <= '0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= btn;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 != level) begin
        // Any agreeing sample in between restarts the count, so only a run of
        // DEBOUNCE_CYCLES consecutive differing samples flips the level.
        if (cnt == CNT_LAST) begin
          level       <= sync2;
          cnt         <= '0;
          press_pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_handshake_unit.sv
// Peripheral side of the core's IN/OUT handshakes: switch capture on a debounced
// ENTER press, and display latching with a delayed done acknowledge.
module io_handshake_unit
  import io_handshake_unit_pkg::*;
#(
  parameter int unsigned DATA_W          = DATA_W_DEFAULT,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned OUT_DELAY       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  output logic              in_ready,
  output logic [DATA_W-1:0] in_data,
  input  logic [SW_W-1:0]   switches,
  input  logic              enter_btn,
  input  logic              new_out,
  input  logic [DATA_W-1:0] out_data,
  output logic              out_done,
  output logic [DATA_W-1:0] display_value,
  output logic              wait_led
);

  localparam int unsigned DLY_W = (OUT_DELAY > 1) ? $clog2(OUT_DELAY + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(OUT_DELAY - 1);

  in_state_t        in_state;
  out_state_t       out_state;
  logic [DLY_W-1:0] dly_cnt;
  logic             btn_level;
  logic             press_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (enter_btn),
    .level      (btn_level),
    .press_pulse(press_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      in_ready <= 1'b0;
      in_data  <= '0;
      wait_led <= 1'b0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (in_req) begin
            in_state <= IN_WAIT;
            wait_led <= 1'b1;
          end
        end
        IN_WAIT: begin
          if (!in_req) begin
            in_state <= IN_IDLE;
            wait_led <= 1'b0;
          end else if (press_pulse) begin
            in_data  <= DATA_W'(switches);
            in_ready <= 1'b1;
            wait_led <= 1'b0;
            in_state <= IN_READY;
          end
        end
        IN_READY: begin
          if (!in_req) begin
            in_ready <= 1'b0;
            in_state <= IN_RELEASE;
          end
        end
        IN_RELEASE: begin
          // A button still held from the last press must be released first,
          // otherwise a back-to-back IN would consume the same press twice.
          if (!btn_level) in_state <= IN_IDLE;
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state     <= OUT_IDLE;
      out_done      <= 1'b0;
      display_value <= '0;
      dly_cnt       <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (new_out) begin
            display_value <= out_data;
            dly_cnt       <= DLY_LOAD;
            out_state     <= OUT_WAIT;
          end
        end
        OUT_WAIT: begin
          if (!new_out) begin
            out_state <= OUT_IDLE;
          end else if (dly_cnt == '0) begin
            out_done  <= 1'b1;
            out_state <= OUT_DONE;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        OUT_DONE: begin
          if (!new_out) begin
            out_done  <= 1'b0;
            out_state <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule
